// File: rtl/cache_refill_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cache_define
// Description : Shared field geometry and controller state encoding for the
//               4-way, 16-line, 16-byte-line cache refill controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_define;

  // Address field widths (tag = addr[31:8], index = addr[7:4], offset = addr[3:0])
  localparam int TAG_WIDTH    = 24;
  localparam int INDEX_WIDTH  = 4;
  localparam int OFFSET_WIDTH = 4;
  localparam int WAY_NUM      = 4;

  // Field slice positions inside a byte address
  localparam int TAG_LSB   = INDEX_WIDTH + OFFSET_WIDTH;
  localparam int INDEX_LSB = OFFSET_WIDTH;
  localparam int WORD_LSB  = 2;

  // Controller state encoding
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] S_LOOKUP    = 3'd1;
  localparam logic [STATE_W-1:0] S_MISS_REQ  = 3'd2;
  localparam logic [STATE_W-1:0] S_MISS_FILL = 3'd3;
  localparam logic [STATE_W-1:0] S_TAG_UPD   = 3'd4;
  localparam logic [STATE_W-1:0] S_RESP      = 3'd5;

  // Any way reporting a hit counts as a hit; several at once is not an error.
  function automatic logic any_way_hit(input logic [WAY_NUM-1:0] hit_vec);
    return |hit_vec;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_refill_ctrl_beat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : refill_beat_cnt
// Description : Refill beat counter. Loads a start word, advances once per
//               accepted beat modulo the line size and flags the final beat
//               (the one after which the counter is back at its start value).
// Revision    : 1.0 - initial release
// ============================================================================
module refill_beat_cnt #(
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_W          = $clog2(WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] start_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] start_q;
  logic [CNT_W-1:0] start_d;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Natural power-of-two wrap gives the modulo-line arithmetic.
  assign w_cnt_nxt = cnt_q + 1'b1;

  // Next-state selection: load wins over increment.
  always_comb begin
    cnt_d   = cnt_q;
    start_d = start_q;
    if (load_i) begin
      cnt_d   = start_i;
      start_d = start_i;
    end else if (inc_i) begin
      cnt_d = w_cnt_nxt;
    end
  end

  // Counter and remembered start value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      start_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = inc_i && (w_cnt_nxt == start_q);

endmodule
`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_refill_ctrl
// Description : Per-request sequencer: tag lookup, 4-beat line refill on a
//               miss, tag commit, then word return to the CPU.
//               Optional build macro CRITICAL_WORD_FIRST_EN: memory returns
//               the requested word first and the response is issued while
//               the rest of the line is still filling.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_refill_ctrl
  import cache_define::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  localparam int CNT_W         = $clog2(WORDS_PER_LINE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_hit,
  output logic                  cache_en,
  output logic [TAG_WIDTH-1:0]  tag,
  output logic [INDEX_WIDTH-1:0] index,
  input  logic [WAY_NUM-1:0]    hit_en,
  input  logic [DATA_WIDTH-1:0] hit_data,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  refill_we,
  output logic [CNT_W-1:0]      refill_word,
  output logic [DATA_WIDTH-1:0] refill_data,
  output logic                  read_main_memory_en,
  output logic [ADDR_WIDTH-1:0] addr_to_main_memory
);

  localparam int LINE_LSB = WORD_LSB + CNT_W;

  logic [STATE_W-1:0]    state_q;
  logic [STATE_W-1:0]    state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic [DATA_WIDTH-1:0] resp_data_d;
  logic                  resp_hit_q;
  logic                  resp_hit_d;
  logic                  resp_valid_q;
  logic                  resp_valid_d;
`ifdef CRITICAL_WORD_FIRST_EN
  logic                  resp_done_q;
  logic                  resp_done_d;
`endif

  logic                  w_hit;
  logic                  w_cnt_load;
  logic                  w_cnt_inc;
  logic                  w_cnt_last;
  logic [CNT_W-1:0]      w_cnt;
  logic [CNT_W-1:0]      w_cnt_start;
  logic [CNT_W-1:0]      w_req_word;
  logic                  w_beat_is_req;
  logic [ADDR_WIDTH-1:0] w_line_addr;
  logic [ADDR_WIDTH-1:0] w_fetch_addr;
  logic                  w_miss_active;
  logic                  w_unused_bits;

  assign w_hit         = any_way_hit(hit_en);
  assign w_req_word    = addr_q[WORD_LSB +: CNT_W];
  assign w_line_addr   = {addr_q[ADDR_WIDTH-1:LINE_LSB], {LINE_LSB{1'b0}}};
  assign w_cnt_load    = (state_q == S_LOOKUP) && !w_hit;
  assign w_cnt_inc     = (state_q == S_MISS_FILL) && mem_rvalid;
  assign w_beat_is_req = (w_cnt == w_req_word);
  assign w_unused_bits = &{1'b0, addr_q[WORD_LSB-1:0]};

`ifdef CRITICAL_WORD_FIRST_EN
  // Fetch starts at the requested word so it arrives on the first beat.
  assign w_cnt_start  = w_req_word;
  assign w_fetch_addr = {addr_q[ADDR_WIDTH-1:WORD_LSB], {WORD_LSB{1'b0}}};
`else
  assign w_cnt_start  = '0;
  assign w_fetch_addr = w_line_addr;
`endif

  refill_beat_cnt #(
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .CNT_W          (CNT_W)
  ) u_beat_cnt (
    .clk     (clk),
    .rst     (rst),
    .load_i  (w_cnt_load),
    .start_i (w_cnt_start),
    .inc_i   (w_cnt_inc),
    .cnt_o   (w_cnt),
    .last_o  (w_cnt_last)
  );

  // Sequencer next-state and response bookkeeping.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    resp_data_d  = resp_data_q;
    resp_hit_d   = resp_hit_q;
    resp_valid_d = resp_valid_q;
`ifdef CRITICAL_WORD_FIRST_EN
    resp_done_d  = resp_done_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef CRITICAL_WORD_FIRST_EN
        resp_done_d = 1'b0;
`endif
        if (req_valid) begin
          addr_d  = req_addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (w_hit) begin
          resp_data_d  = hit_data;
          resp_hit_d   = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          resp_hit_d = 1'b0;
          state_d    = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        if (mem_gnt) begin
          state_d = S_MISS_FILL;
        end
      end
      S_MISS_FILL: begin
        if (mem_rvalid) begin
          if (w_beat_is_req) begin
            resp_data_d = mem_rdata;
`ifdef CRITICAL_WORD_FIRST_EN
            resp_valid_d = 1'b1;
`endif
          end
          if (w_cnt_last) begin
            state_d = S_TAG_UPD;
          end
        end
      end
      S_TAG_UPD: begin
        resp_hit_d = 1'b0;
`ifndef CRITICAL_WORD_FIRST_EN
        resp_valid_d = 1'b1;
`endif
        state_d = S_RESP;
      end
      S_RESP: begin
`ifdef CRITICAL_WORD_FIRST_EN
        // Early response may already have been taken during the fill.
        if (resp_done_q || (resp_valid_q && resp_ready)) begin
          state_d = S_IDLE;
        end
`else
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef CRITICAL_WORD_FIRST_EN
    // The CPU handshake can land in any state once the response is up.
    if (resp_valid_q && resp_ready) begin
      resp_valid_d = 1'b0;
      resp_done_d  = 1'b1;
    end
`endif
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      resp_data_q  <= '0;
      resp_hit_q   <= 1'b0;
      resp_valid_q <= 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
      resp_done_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      resp_data_q  <= resp_data_d;
      resp_hit_q   <= resp_hit_d;
      resp_valid_q <= resp_valid_d;
`ifdef CRITICAL_WORD_FIRST_EN
      resp_done_q  <= resp_done_d;
`endif
    end
  end

  // Line address stays on the commit bus for the whole miss, so the tag
  // store has it registered before the commit strobe.
  assign w_miss_active = (state_q == S_MISS_REQ)  || (state_q == S_MISS_FILL) ||
                         (state_q == S_TAG_UPD)   ||
                         ((state_q == S_RESP) && !resp_hit_q);

  assign req_ready           = (state_q == S_IDLE);
  assign cache_en            = (state_q == S_LOOKUP);
  assign tag                 = addr_q[TAG_LSB +: TAG_WIDTH];
  assign index               = addr_q[INDEX_LSB +: INDEX_WIDTH];
  assign mem_req             = (state_q == S_MISS_REQ);
  assign mem_addr            = mem_req ? w_fetch_addr : '0;
  assign refill_we           = w_cnt_inc;
  assign refill_word         = w_cnt_inc ? w_cnt : '0;
  assign refill_data         = w_cnt_inc ? mem_rdata : '0;
  assign read_main_memory_en = (state_q == S_TAG_UPD);
  assign addr_to_main_memory = w_miss_active ? w_line_addr : '0;
  assign resp_valid          = resp_valid_q;
  assign resp_data           = resp_data_q;
  assign resp_hit            = resp_hit_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_refill_ctrl
// Description : Directed self-checking bench for cache_refill_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_hit;
  logic        cache_en;
  logic [23:0] tag;
  logic [3:0]  index;
  logic [3:0]  hit_en;
  logic [31:0] hit_data;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        refill_we;
  logic [1:0]  refill_word;
  logic [31:0] refill_data;
  logic        read_main_memory_en;
  logic [31:0] addr_to_main_memory;

  int n_checks = 0;
  int n_errors = 0;

  int          we_cnt   = 0;
  int          rmm_cnt  = 0;
  int          mreq_cnt = 0;
  logic [31:0] rmm_addr = '0;
  logic [1:0]  words[$];

  cache_refill_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_addr            (req_addr),
    .resp_valid          (resp_valid),
    .resp_ready          (resp_ready),
    .resp_data           (resp_data),
    .resp_hit            (resp_hit),
    .cache_en            (cache_en),
    .tag                 (tag),
    .index               (index),
    .hit_en              (hit_en),
    .hit_data            (hit_data),
    .mem_req             (mem_req),
    .mem_gnt             (mem_gnt),
    .mem_addr            (mem_addr),
    .mem_rvalid          (mem_rvalid),
    .mem_rdata           (mem_rdata),
    .refill_we           (refill_we),
    .refill_word         (refill_word),
    .refill_data         (refill_data),
    .read_main_memory_en (read_main_memory_en),
    .addr_to_main_memory (addr_to_main_memory)
  );

  always #5 clk = ~clk;

  // Event monitor: data-store writes, tag commits and memory requests.
  always @(posedge clk) begin
    if (refill_we) begin
      we_cnt <= we_cnt + 1;
      words.push_back(refill_word);
    end
    if (read_main_memory_en) begin
      rmm_cnt  <= rmm_cnt + 1;
      rmm_addr <= addr_to_main_memory;
    end
    if (mem_req) begin
      mreq_cnt <= mreq_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_maddr(input logic [31:0] a);
`ifdef CRITICAL_WORD_FIRST_EN
    return {a[31:2], 2'b00};
`else
    return {a[31:4], 4'b0000};
`endif
  endfunction

  function automatic logic [1:0] exp_word(input logic [31:0] a, input int i);
    logic [1:0] s;
    logic [1:0] k;
`ifdef CRITICAL_WORD_FIRST_EN
    s = a[3:2];
`else
    s = 2'd0;
`endif
    k = i[1:0];
    return s + k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [3:0] he, input logic [31:0] hd);
    req_addr  = a;
    req_valid = 1'b1;
    hit_en    = he;
    hit_data  = hd;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    bit ok;
    ok = 0;
    for (int n = 0; n < 30; n++) begin
      if (resp_valid) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("resp_valid_seen", ok, 1);
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("resp_valid_drop", resp_valid, 0);
    chk("req_ready_back", req_ready, 1);
  endtask

  // Memory side of one full miss; word w of the line carries base + w.
  task automatic serve_miss(input logic [31:0] a, input int gnt_dly, input int gap,
                            input logic [31:0] base);
    bit seen;
    bit hold_ok;
    words.delete();
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      if (mem_req) begin
        seen = 1;
        break;
      end
      tick();
    end
    chk("mem_req_seen", seen, 1);
    chk("mem_addr", mem_addr, exp_maddr(a));
    chk("a2mm_in_req", addr_to_main_memory, {a[31:4], 4'b0000});
    hold_ok = 1;
    for (int n = 0; n < gnt_dly; n++) begin
      tick();
      if (!(mem_req && (mem_addr == exp_maddr(a)))) hold_ok = 0;
    end
    chk("mem_req_hold", hold_ok, 1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("mem_req_drop", mem_req, 0);
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) tick();
      mem_rvalid = 1'b1;
      mem_rdata  = base + 32'(exp_word(a, b));
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hFFFF_FFFF;
      if (b == 0) begin
`ifdef CRITICAL_WORD_FIRST_EN
        chk("resp_after_first_beat", resp_valid, 1);
`else
        chk("resp_after_first_beat", resp_valid, 0);
`endif
      end
    end
    chk("tag_commit_pulse", read_main_memory_en, 1);
    tick();
    chk("tag_commit_single", read_main_memory_en, 0);
  endtask

  task automatic check_words(input logic [31:0] a);
    chk("refill_beats", words.size(), 4);
    for (int i = 0; i < 4 && i < words.size(); i++) begin
      chk("refill_word_order", words[i], exp_word(a, i));
    end
  endtask

  initial begin
    int w0;
    int r0;
    int m0;
    bit stable;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    resp_ready = 1'b0;
    hit_en     = '0;
    hit_data   = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    tick();
    tick();

    // Reset values
    chk("rst_req_ready", req_ready, 1);
    chk("rst_outputs_zero",
        {resp_valid, resp_hit, cache_en, mem_req, refill_we, read_main_memory_en},
        6'b0);
    chk("rst_buses_zero", {resp_data, tag, index, mem_addr, addr_to_main_memory},
        124'h0);
    rst = 1'b0;
    tick();

    // Hit: tag 0x000012, index 3, way 1
    m0 = mreq_cnt;
    issue(32'h0000_1234, 4'b0010, 32'hCAFE_F00D);
    chk("hit_cache_en", cache_en, 1);
    chk("hit_tag", tag, 24'h000012);
    chk("hit_index", index, 4'h3);
    chk("hit_req_ready_low", req_ready, 0);
    chk("hit_resp_not_yet", resp_valid, 0);
    tick();
    chk("hit_resp_valid_2cyc", resp_valid, 1);
    chk("hit_resp_hit", resp_hit, 1);
    chk("hit_resp_data", resp_data, 32'hCAFE_F00D);
    chk("hit_a2mm_zero", addr_to_main_memory, 32'h0);
    finish_resp();
    chk("hit_no_mem_req", mreq_cnt - m0, 0);

    // Multiple ways hitting is still a hit
    issue(32'h0000_5678, 4'b1011, 32'h1111_2222);
    tick();
    chk("multihit_valid", resp_valid, 1);
    chk("multihit_hit", resp_hit, 1);
    chk("multihit_data", resp_data, 32'h1111_2222);
    finish_resp();

    // Miss on 0x1238, line 0x1230, requested word 2
    w0 = we_cnt;
    r0 = rmm_cnt;
    issue(32'h0000_1238, 4'b0000, 32'hDEAD_BEEF);
    serve_miss(32'h0000_1238, 0, 0, 32'h0000_00A0);
    wait_resp();
    chk("miss_resp_data", resp_data, 32'h0000_00A2);
    chk("miss_resp_hit", resp_hit, 0);
    chk("miss_we_count", we_cnt - w0, 4);
    chk("miss_commit_count", rmm_cnt - r0, 1);
    chk("miss_commit_addr", rmm_addr, 32'h0000_1230);
    check_words(32'h0000_1238);
    finish_resp();
    chk("idle_a2mm_zero", addr_to_main_memory, 32'h0);

    // Stalled grant and gapped beats
    w0 = we_cnt;
    r0 = rmm_cnt;
    issue(32'h0000_ABC4, 4'b0000, 32'h0);
    serve_miss(32'h0000_ABC4, 5, 2, 32'h0000_00B0);
    wait_resp();
    chk("stall_resp_data", resp_data, 32'h0000_00B1);
    chk("stall_we_count", we_cnt - w0, 4);
    chk("stall_commit_count", rmm_cnt - r0, 1);
    chk("stall_commit_addr", rmm_addr, 32'h0000_ABC0);
    check_words(32'h0000_ABC4);
    finish_resp();

    // Response backpressure with a competing request
    issue(32'h0000_4448, 4'b0100, 32'h0BAD_CAFE);
    tick();
    chk("bp_resp_valid", resp_valid, 1);
    req_valid = 1'b1;
    req_addr  = 32'h9999_0000;
    stable = 1;
    for (int n = 0; n < 7; n++) begin
      tick();
      if (!(resp_valid && resp_data == 32'h0BAD_CAFE && !req_ready && !cache_en))
        stable = 0;
    end
    chk("bp_stable", stable, 1);
    chk("bp_tag_not_relatched", tag, 24'h000044);
    req_valid = 1'b0;
    finish_resp();
    tick();
    chk("bp_no_lookup", cache_en, 0);

    // Reset during beat 2 of a fill
    w0 = we_cnt;
    r0 = rmm_cnt;
    issue(32'h0000_3310, 4'b0000, 32'h0);
    tick();
    chk("rstfill_mem_req", mem_req, 1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hC0 + b;
      tick();
    end
    mem_rdata = 32'hC2;
    #2;
    rst = 1'b1;
    #1;
    chk("rstfill_async_idle", req_ready, 1);
    tick();
    rst        = 1'b0;
    mem_rvalid = 1'b0;
    chk("rstfill_we_count", we_cnt - w0, 2);
    chk("rstfill_no_commit", rmm_cnt - r0, 0);
    chk("rstfill_no_resp", resp_valid, 0);
    tick();
    chk("rstfill_req_ready", req_ready, 1);
    chk("rstfill_no_commit_later", rmm_cnt - r0, 0);
    r0 = rmm_cnt;
    issue(32'h0000_3310, 4'b0000, 32'h0);
    serve_miss(32'h0000_3310, 0, 1, 32'h0000_00D0);
    wait_resp();
    chk("rereq_resp_data", resp_data, 32'h0000_00D0);
    chk("rereq_commit_addr", rmm_addr, 32'h0000_3310);
    chk("rereq_commit_count", rmm_cnt - r0, 1);
    finish_resp();

`ifdef CRITICAL_WORD_FIRST_EN
    // Critical word first on the last word of a line
    w0 = we_cnt;
    issue(32'h0000_123C, 4'b0000, 32'h0);
    serve_miss(32'h0000_123C, 0, 0, 32'h0000_00E0);
    wait_resp();
    chk("cwf_resp_data", resp_data, 32'h0000_00E3);
    chk("cwf_we_count", we_cnt - w0, 4);
    check_words(32'h0000_123C);
    finish_resp();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Per-request sequencer for the 4-way, 16-line, 16-byte-line cache (tag = addr[31:8], index = addr[7:4], word = addr[3:2]).
- Accepts one CPU read at a time and drives tag/index into the tag store for lookup.
- On a miss, runs a 4-beat line refill from main memory into the data store.
- After the refill, commits the new tag via read_main_memory_en / addr_to_main_memory, then returns the requested word.
- Sits between the CPU load port, the tag/data stores and the main-memory read bus.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, word width
WORDS_PER_LINE, 4, beats per refill (power of 2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  CPU read request
req_ready  out  1  controller can accept a request
req_addr  in  ADDR_WIDTH  CPU byte address
resp_valid  out  1  response available
resp_ready  in  1  CPU accepts response
resp_data  out  DATA_WIDTH  returned word
resp_hit  out  1  1 = served from cache, 0 = served by refill
cache_en  out  1  lookup strobe to tag store / LRU
tag  out  24  latched addr[31:8]
index  out  4  latched addr[7:4]
hit_en  in  4  per-way hit from tag store
hit_data  in  DATA_WIDTH  data-store word for hitting way, same cycle as hit_en
mem_req  out  1  memory read request
mem_gnt  in  1  memory accepted request
mem_addr  out  ADDR_WIDTH  line-aligned address (addr[3:0] = 0)
mem_rvalid  in  1  memory read beat valid
mem_rdata  in  DATA_WIDTH  memory read beat
refill_we  out  1  data-store write strobe
refill_word  out  2  word offset within line being written
refill_data  out  DATA_WIDTH  word to write
read_main_memory_en  out  1  tag-store commit strobe
addr_to_main_memory  out  ADDR_WIDTH  line address for tag commit

Behaviour:
- Reset values: all outputs 0 except req_ready = 1. State = IDLE, beat counter = 0.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch req_addr, go to LOOKUP.
- LOOKUP (exactly 1 cycle):
  - cache_en = 1; tag/index driven from the latched address.
  - |hit_en = 1: capture hit_data, set resp_hit = 1, go to RESP. Latency from accept to resp_valid is 2 cycles.
  - Multiple hit_en bits set: still a hit, no error.
  - Otherwise go to MISS_REQ.
- MISS_REQ:
  - mem_req = 1, with mem_addr = {addr[31:4], 4'b0} held until mem_gnt, then go to MISS_FILL.
  - addr_to_main_memory is driven with the line address from entry to MISS_REQ until return to IDLE. The tag store registers it one cycle before the commit.
- MISS_FILL:
  - Each mem_rvalid produces refill_we = 1, refill_word = beat counter, refill_data = mem_rdata; counter then increments.
  - The beat whose counter equals addr[3:2] is captured into resp_data.
  - Gaps without mem_rvalid are allowed.
  - After beat WORDS_PER_LINE-1, the counter wraps to 0; go to TAG_UPD.
- TAG_UPD (1 cycle): read_main_memory_en = 1, resp_hit = 0, then go to RESP.
- RESP:
  - resp_valid = 1 and resp_data stable until resp_ready.
  - On resp_ready go to IDLE; resp_valid drops the next cycle.
  - req_ready = 0 outside IDLE, so there is no back-to-back overlap.
- Ignored inputs:
  - mem_rvalid outside MISS_FILL.
  - mem_gnt outside MISS_REQ.
  - hit_en outside LOOKUP.
- Reset mid-operation (any state):
  - Immediate return to IDLE.
  - No read_main_memory_en pulse, no resp_valid.
  - Partially written line stays invalid: its tag was never committed.
- Beat counter width: log2(WORDS_PER_LINE); arithmetic modulo the line size.

Optional Feature:
CRITICAL_WORD_FIRST_EN
- Defined:
  - mem_addr carries addr[3:2] in the word field; memory returns the requested word first.
  - Beat counter starts at addr[3:2] and wraps modulo WORDS_PER_LINE.
  - resp_valid asserts on the cycle after the first beat, concurrent with the remaining fill.
  - TAG_UPD still follows the last beat. Return to IDLE requires both fill done and resp handshake done, in either order.
- Undefined: mem_addr fully line-aligned, fill order 0..3, response only after TAG_UPD.

Decomposition:
- Shared cache_define package holds:
  - state encoding (IDLE, LOOKUP, MISS_REQ, MISS_FILL, TAG_UPD, RESP);
  - field constants TAG_WIDTH = 24, INDEX_WIDTH = 4, OFFSET_WIDTH = 4, WAY_NUM = 4;
  - field-slice positions.
- One natural sub-module, refill_beat_cnt: beat counter with start value, wrap and done flag.

Test Plan:
- Hit: preload tag 0x000012 at index 3, way 1; request 0x00001234 with hit_en = 4'b0010 and hit_data = 0xCAFEF00D -> resp_valid 2 cycles after accept, resp_hit = 1, resp_data = 0xCAFEF00D, no mem_req.
- Miss: request 0x00001238; memory returns 0xA0, 0xA1, 0xA2, 0xA3 -> mem_addr = 0x00001230, refill_word 0..3, one read_main_memory_en pulse with addr_to_main_memory = 0x00001230, resp_data = 0xA2, resp_hit = 0.
- Stalled grant and gapped beats: mem_gnt delayed 5 cycles, 2-cycle gaps between beats -> mem_req and mem_addr held stable, exactly 4 refill_we pulses.
- Response backpressure: resp_ready low for 7 cycles -> resp_valid and resp_data stable, req_ready = 0, a new req_valid is not accepted.
- Reset at beat 2 of a fill -> no read_main_memory_en; req_ready = 1 on the cycle after reset deasserts; re-request of the same address misses again.
- With CRITICAL_WORD_FIRST_EN, request 0x0000123C -> mem_addr = 0x0000123C, refill_word order 3, 0, 1, 2, resp_valid after the first beat.
